mod12_wrap_tracker: RTL and testbench



---
 rtl/wtrk_pkg.sv | 26 ++
 rtl/wtrk_evt_fifo.sv | 55 +++++
 rtl/mod12_wrap_tracker.sv | 165 ++++++++++++++++
 tb/tb_mod12_wrap_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wtrk_pkg.sv
// Shared types and constants for the mod-12 wrap tracker.
// Optional feature macro: WTRK_OVF_CNT_EN (adds the ovf_cnt output on the top).
package wtrk_pkg;

    localparam logic [3:0] CNT_MOD = 4'd12;
    localparam logic [3:0] CNT_MAX = 4'd11;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } wtrk_state_t;

    typedef enum logic [1:0] {
        UP_WRAP = 2'd0,
        DN_WRAP = 2'd1,
        LOAD    = 2'd2,
        ERROR   = 2'd3
    } wtrk_evt_t;

    typedef struct packed {
        wtrk_evt_t   typ;
        logic [3:0]  val;
    } wtrk_evt_s;

endpackage

// File: rtl/wtrk_evt_fifo.sv
// Synchronous event FIFO with valid/ready pop. Not first-word fall-through:
// a pushed word is visible at the head on the cycle after the push.
// Head output holds the last popped word while the FIFO is empty.
module wtrk_evt_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic [DATA_W-1:0] hold_q;
    logic              pop_ok;
    logic              push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs when full.
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and held-head update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + (AW+1)'(1);
            if (pop_ok) begin
                rd_q   <= rd_q + (AW+1)'(1);
                hold_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

    // Storage write; contents need no reset since empty gates the head
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mod12_wrap_tracker.sv
// Mod-12 counter output tracker: checks each sampled step, keeps a net wrap
// count and reports wrap/load/error events through a small FIFO.
// Optional feature macro: WTRK_OVF_CNT_EN adds an 8-bit saturating ovf_cnt.
module mod12_wrap_tracker
    import wtrk_pkg::*;
#(
    parameter int WRAP_W    = 8,
    parameter int EVT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cnt_valid,
    input  logic [3:0]        cnt_in,
    input  logic              load,
    input  logic              up_down,
    input  logic              clr_err,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_type,
    output logic [3:0]        evt_val,
    output logic              err_sticky,
    output logic              ovf_sticky
`ifdef WTRK_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    wtrk_state_t       state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        exp_val;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              err_q, ovf_q;
    logic              legal;
    logic              push;
    logic              err_set;
    logic              drop;
    logic              fifo_full, fifo_empty;
    wtrk_evt_s         push_evt;
    wtrk_evt_s         head_evt;

    assign legal   = (cnt_in < CNT_MOD);
    assign exp_val = up_down ? ((prev_q == CNT_MAX) ? 4'd0 : prev_q + 4'd1)
                             : ((prev_q == 4'd0) ? CNT_MAX : prev_q - 4'd1);

    // State, previous value and wrap count registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= INIT;
            prev_q  <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            wrap_q  <= wrap_d;
        end
    end

    // Sample checking: next state, event to push and wrap count update
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_d       = wrap_q;
        push         = 1'b0;
        err_set      = 1'b0;
        push_evt.typ = LOAD;
        push_evt.val = cnt_in;
        if (cnt_valid) begin
            case (state_q)
                INIT, FAULT: begin
                    if (load && legal) begin
                        prev_d  = cnt_in;
                        push    = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        push         = 1'b1;
                        push_evt.typ = ERROR;
                        err_set      = 1'b1;
                        state_d      = FAULT;
                    end else if (load) begin
                        prev_d = cnt_in;
                        push   = 1'b1;
                    end else if (cnt_in == exp_val) begin
                        prev_d = cnt_in;
                        if (up_down && prev_q == CNT_MAX) begin
                            push         = 1'b1;
                            push_evt.typ = UP_WRAP;
                            wrap_d       = wrap_q + WRAP_W'(1);
                        end else if (!up_down && prev_q == 4'd0) begin
                            push         = 1'b1;
                            push_evt.typ = DN_WRAP;
                            wrap_d       = wrap_q - WRAP_W'(1);
                        end
                    end else begin
                        push         = 1'b1;
                        push_evt.typ = ERROR;
                        err_set      = 1'b1;
                        state_d      = FAULT;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    // A full FIFO only has room when the consumer pops the head this cycle.
    assign drop = push && fifo_full && !evt_ready;

    // Sticky flags: a new set beats a coincident clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            err_q <= err_set || (err_q && !clr_err);
            ovf_q <= drop    || (ovf_q && !clr_err);
        end
    end

    wtrk_evt_fifo #(
        .DATA_W ($bits(wtrk_evt_s)),
        .DEPTH  (EVT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .din_i   (push_evt),
        .pop_i   (evt_ready),
        .dout_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wrap_cnt   = wrap_q;
    assign evt_valid  = !fifo_empty;
    assign evt_type   = head_evt.typ;
    assign evt_val    = head_evt.val;
    assign err_sticky = err_q;
    assign ovf_sticky = ovf_q;

`ifdef WTRK_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop)
            ovf_cnt_d = clr_err ? 8'd1 : ((ovf_cnt_q == 8'hFF) ? ovf_cnt_q : ovf_cnt_q + 8'd1);
        else if (clr_err)
            ovf_cnt_d = '0;
    end

    // Saturating dropped-event counter
    always_ff @(posedge clk) begin
        if (!rstn) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mod12_wrap_tracker.sv
// Self-checking bench for mod12_wrap_tracker: directed scenarios followed by
// randomized samples, compared against a queue-based reference model.
module tb_mod12_wrap_tracker;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cnt_valid = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       load = 1'b0;
    logic       up_down = 1'b0;
    logic       clr_err = 1'b0;
    logic       evt_ready = 1'b0;
    logic [7:0] wrap_cnt;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [3:0] evt_val;
    logic       err_sticky;
    logic       ovf_sticky;
`ifdef WTRK_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    // Reference model: mode 0=waiting for load, 1=tracking, 2=faulted
    int m_mode, m_prev, m_wrap, m_last;
    bit m_err, m_ovf;
    int m_ovfc;
    int m_q[$];   // events encoded as type*16 + value

    mod12_wrap_tracker #(.WRAP_W(8), .EVT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cnt_valid  (cnt_valid),
        .cnt_in     (cnt_in),
        .load       (load),
        .up_down    (up_down),
        .clr_err    (clr_err),
        .wrap_cnt   (wrap_cnt),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_type   (evt_type),
        .evt_val    (evt_val),
        .err_sticky (err_sticky),
        .ovf_sticky (ovf_sticky)
`ifdef WTRK_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_wrap = 0; m_last = 0;
        m_err = 0; m_ovf = 0; m_ovfc = 0;
        m_q.delete();
    endtask

    // One clock of the reference behaviour for the inputs currently driven
    task automatic model_cycle();
        bit pop, do_push, e_set, o_set;
        int ev, nxt, v;
        if (!rstn) begin
            model_reset();
            return;
        end
        v = int'(cnt_in);
        pop = evt_ready && (m_q.size() > 0);
        do_push = 0; e_set = 0; o_set = 0; ev = 0;
        if (cnt_valid) begin
            if (m_mode == 1) begin
                if (v >= 12) begin
                    do_push = 1; ev = 3*16 + v; e_set = 1; m_mode = 2;
                end else if (load) begin
                    do_push = 1; ev = 2*16 + v; m_prev = v;
                end else begin
                    nxt = up_down ? (m_prev + 1) % 12 : (m_prev + 11) % 12;
                    if (v == nxt) begin
                        if (up_down && nxt == 0)   begin do_push = 1; ev = 0*16 + v; m_wrap++; end
                        if (!up_down && nxt == 11) begin do_push = 1; ev = 1*16 + v; m_wrap--; end
                        m_prev = v;
                    end else begin
                        do_push = 1; ev = 3*16 + v; e_set = 1; m_mode = 2;
                    end
                end
            end else if (load && v < 12) begin
                do_push = 1; ev = 2*16 + v; m_prev = v; m_mode = 1;
            end
        end
        if (pop) m_last = m_q.pop_front();
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else o_set = 1;
        end
        m_err = e_set ? 1'b1 : (clr_err ? 1'b0 : m_err);
        m_ovf = o_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        if (o_set)        m_ovfc = clr_err ? 1 : ((m_ovfc < 255) ? m_ovfc + 1 : 255);
        else if (clr_err) m_ovfc = 0;
    endtask

    task automatic check_all(input string tag);
        int head;
        head = (m_q.size() > 0) ? m_q[0] : m_last;
        chk({tag, ".evt_valid"},  32'(evt_valid),  32'(m_q.size() > 0));
        chk({tag, ".evt_type"},   32'(evt_type),   32'(head / 16));
        chk({tag, ".evt_val"},    32'(evt_val),    32'(head % 16));
        chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(m_wrap & 8'hFF));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
        chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_ovf));
`ifdef WTRK_OVF_CNT_EN
        chk({tag, ".ovf_cnt"},    32'(ovf_cnt),    32'(m_ovfc));
`endif
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare
    task automatic step(input string tag, input bit v, input int val, input bit ld,
                        input bit up, input bit clr, input bit rdy);
        cnt_valid = v; cnt_in = 4'(val); load = ld; up_down = up;
        clr_err = clr; evt_ready = rdy;
        model_cycle();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        step(tag, 1, 3, 1, 1, 0, 0);
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++) step(tag, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int pick;
        bit v, ld, up, clr, rdy;
        model_reset();
        #1;

        // Reset state
        do_reset("reset");

        // Samples ignored before the first load
        step("init5", 1, 5, 0, 1, 0, 0);
        step("init6", 1, 6, 0, 1, 0, 0);
        chk("init.no_evt", 32'(evt_valid), 32'd0);
        step("load3", 1, 3, 1, 1, 0, 0);
        chk("load3.type", 32'(evt_type), 32'd2);
        chk("load3.val",  32'(evt_val),  32'd3);
        drain("drain1");

        // Up wrap
        step("load10", 1, 10, 1, 1, 0, 0);
        step("up11",   1, 11, 0, 1, 0, 0);
        step("up0",    1, 0,  0, 1, 0, 0);
        step("up1",    1, 1,  0, 1, 0, 0);
        chk("upwrap.wrap", 32'(wrap_cnt), 32'd1);
        drain("drain2");

        // Down wrap twice nets to -1 from +1 start? Start from 1 wrap: LOAD(1), 0, 11, 10
        step("load1", 1, 1,  1, 0, 0, 0);
        step("dn0",   1, 0,  0, 0, 0, 0);
        step("dn11",  1, 11, 0, 0, 0, 0);
        step("dn10",  1, 10, 0, 0, 0, 0);
        chk("dnwrap.wrap", 32'(wrap_cnt), 32'd0);
        step("load1b", 1, 1,  1, 0, 0, 0);
        step("dn0b",   1, 0,  0, 0, 0, 0);
        step("dn11b",  1, 11, 0, 0, 0, 0);
        chk("dnwrap.ff", 32'(wrap_cnt), 32'hFF);
        drain("drain3");

        // Step error, ignored samples in fault, resync, clear
        step("load4",  1, 4, 1, 1, 0, 0);
        step("bad7",   1, 7, 0, 1, 0, 0);
        chk("bad7.err", 32'(err_sticky), 32'd1);
        step("flt8",   1, 8, 0, 1, 0, 0);
        step("flt9",   1, 9, 0, 1, 0, 0);
        step("load2",  1, 2, 1, 1, 0, 0);
        step("up3",    1, 3, 0, 1, 0, 0);
        step("clr",    0, 0, 0, 0, 1, 0);
        chk("clr.err", 32'(err_sticky), 32'd0);
        step("illegal", 1, 13, 1, 1, 1, 0);   // error beats clear, and beats load
        drain("drain4");
        step("clr2",   0, 0, 0, 0, 1, 0);

        // Overflow: hold ready low through 24 up steps and two extra loads
        do_reset("reset2");
        step("ov.load0", 1, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 24; i++) step("ov.up", 1, i % 12, 0, 1, 0, 0);
        step("ov.load5", 1, 5, 1, 1, 0, 0);
        step("ov.load6", 1, 6, 1, 1, 0, 0);
        chk("ov.sticky", 32'(ovf_sticky), 32'd1);
        chk("ov.wrap",   32'(wrap_cnt),   32'd2);
        step("ov.clr",   0, 0, 0, 0, 1, 0);
        // Full FIFO, pop and push together: accepted, no overflow
        step("ov.pp",    1, 7, 1, 1, 0, 1);
        chk("ov.pp.ovf", 32'(ovf_sticky), 32'd0);
        drain("drain5");

        // Reset mid-stream flushes everything
        step("ms.load9", 1, 9, 1, 1, 0, 0);
        step("ms.up10",  1, 10, 0, 1, 0, 0);
        step("ms.up11",  1, 11, 0, 1, 0, 0);
        step("ms.up0",   1, 0, 0, 1, 0, 0);
        do_reset("ms.reset");
        chk("ms.valid", 32'(evt_valid), 32'd0);
        chk("ms.wrap",  32'(wrap_cnt),  32'd0);

        // Randomized samples, mostly legal steps
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset("rnd.reset");
            pick = int'($urandom_range(0, 99));
            v    = ($urandom_range(0, 99) < 75);
            ld   = ($urandom_range(0, 99) < 8);
            up   = $urandom_range(0, 1) == 1;
            clr  = ($urandom_range(0, 99) < 4);
            rdy  = ($urandom_range(0, 99) < 45);
            if (pick < 85)
                step("rnd", v, up ? (m_prev + 1) % 12 : (m_prev + 11) % 12, ld, up, clr, rdy);
            else
                step("rnd", v, int'($urandom_range(0, 15)), ld, up, clr, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
